// File: rtl/median_window_filter.sv
// Streaming 5-tap sliding-window median filter.
// The median is found by odd-even transposition sort, one pass per clock.
module median_window_filter #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [2:0]        fill_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        SORT,
        OUT
    } state_t;

    state_t state;
    state_t state_nx;

    logic [4:0][DATA_W-1:0] win;
    logic [4:0][DATA_W-1:0] scr;
    logic [4:0][DATA_W-1:0] scr_nx;
    logic [2:0]             pass_cnt;
    logic [2:0]             fill_inc;
    logic                   accept;
    logic                   last_pass;
    logic                   win_full;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);
    assign accept    = in_valid & in_ready & ~flush;
    assign last_pass = (pass_cnt == 3'd4);
    assign fill_inc  = (fill_cnt == 3'd5) ? 3'd5 : fill_cnt + 3'd1;
    assign win_full  = (fill_inc == 3'd5);

    // Returns {min, max}; equal values keep their order.
    function automatic logic [2*DATA_W-1:0] cswap(
        input logic [DATA_W-1:0] lo,
        input logic [DATA_W-1:0] hi
    );
        if (lo > hi) begin
            return {hi, lo};
        end
        return {lo, hi};
    endfunction

    always_comb begin
        scr_nx = scr;
        if (!pass_cnt[0]) begin
            {scr_nx[0], scr_nx[1]} = cswap(scr[0], scr[1]);
            {scr_nx[2], scr_nx[3]} = cswap(scr[2], scr[3]);
        end else begin
            {scr_nx[1], scr_nx[2]} = cswap(scr[1], scr[2]);
            {scr_nx[3], scr_nx[4]} = cswap(scr[3], scr[4]);
        end
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept && win_full) begin
                        state_nx = SORT;
                    end
                end
                SORT: begin
                    if (last_pass) begin
                        state_nx = OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win      <= '0;
            scr      <= '0;
            pass_cnt <= '0;
            fill_cnt <= '0;
            out_data <= '0;
        end else if (flush) begin
            win      <= '0;
            fill_cnt <= '0;
            pass_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        win      <= {win[3:0], in_data};
                        fill_cnt <= fill_inc;
                        if (win_full) begin
                            // Sort the updated window, not the old one.
                            scr      <= {win[3:0], in_data};
                            pass_cnt <= '0;
                        end
                    end
                end
                SORT: begin
                    scr      <= scr_nx;
                    pass_cnt <= pass_cnt + 3'd1;
                    if (last_pass) begin
                        out_data <= scr_nx[2];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_median_window_filter.sv
// Directed bench for median_window_filter.
// Vectors and expected medians are worked out by hand.
module tb_median_window_filter;

    localparam int DATA_W = 4;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [2:0]        fill_cnt;

    int n_pass;
    int n_total;

    median_window_filter #(.DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .fill_cnt (fill_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int v);
        in_valid = 1'b1;
        in_data  = DATA_W'(v);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic push_warm(input int v, input int exp_fill);
        push(v);
        check("warm_fill", int'(fill_cnt), exp_fill);
        check("warm_noval", int'(out_valid), 0);
        check("warm_rdy", int'(in_ready), 1);
    endtask

    // Called right after the 5th accept edge; the median lands 5 edges later.
    task automatic wait_median(input string tag, input int exp);
        int early;
        early = 0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (out_valid !== 1'b0) early++;
        end
        check({tag, "_early"}, early, 0);
        tick();
        check({tag, "_valid"}, int'(out_valid), 1);
        check({tag, "_data"}, int'(out_data), exp);
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        tick();
        check({tag, "_drop"}, int'(out_valid), 0);
        check({tag, "_rdy"}, int'(in_ready), 1);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #2;
        check("rst_valid", int'(out_valid), 0);
        check("rst_data", int'(out_data), 0);
        check("rst_fill", int'(fill_cnt), 0);
        check("rst_rdy", int'(in_ready), 1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Warm-up: 3,9,1,7,5 -> 5
        push_warm(3, 1);
        push_warm(9, 2);
        push_warm(1, 3);
        push_warm(7, 4);
        push(5);
        check("fill5", int'(fill_cnt), 5);
        check("sort_busy", int'(in_ready), 0);
        wait_median("first", 5);
        drain("first");

        // Slide in 8 under backpressure: 9,1,7,5,8 -> 7
        out_ready = 1'b0;
        push(8);
        in_valid = 1'b1;
        in_data  = 4'd12;
        wait_median("bp", 7);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_hold_valid", int'(out_valid), 1);
            check("bp_hold_data", int'(out_data), 7);
            check("bp_hold_rdy", int'(in_ready), 0);
        end
        check("bp_fill", int'(fill_cnt), 5);
        in_valid = 1'b0;
        drain("bp");
        check("bp_keep_data", int'(out_data), 7);

        // 1,7,5,8,0 -> 5 (a consumed 12 would give 7)
        push(0);
        wait_median("slide0", 5);
        drain("slide0");

        do_flush();
        check("flush_fill", int'(fill_cnt), 0);
        push_warm(2, 1);
        push_warm(2, 2);
        push_warm(2, 3);
        push_warm(9, 4);
        push(9);
        wait_median("ties", 2);
        drain("ties");

        do_flush();
        push(15);
        push(15);
        push(0);
        push(0);
        push(15);
        wait_median("maxes", 15);
        drain("maxes");

        do_flush();
        push(0);
        push(0);
        push(0);
        push(0);
        push(0);
        wait_median("zeros", 0);
        drain("zeros");

        // Flush with a concurrent sample
        do_flush();
        push(1);
        push(2);
        push(3);
        check("pre_flush_fill", int'(fill_cnt), 3);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'd9;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_drop_fill", int'(fill_cnt), 0);
        check("flush_rdy", int'(in_ready), 1);
        push_warm(4, 1);
        push_warm(4, 2);
        push_warm(4, 3);
        push_warm(4, 4);
        push(4);
        wait_median("refill", 4);
        drain("refill");

        // Reset during SORT pass 2
        do_flush();
        push(6);
        push(6);
        push(6);
        push(6);
        push(6);
        tick();
        tick();
        check("mid_sort", int'(in_ready), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", int'(out_valid), 0);
        check("arst_data", int'(out_data), 0);
        check("arst_fill", int'(fill_cnt), 0);
        check("arst_rdy", int'(in_ready), 1);
        tick();
        rst_n = 1'b1;
        push_warm(3, 1);
        push_warm(8, 2);
        push_warm(1, 3);
        push_warm(8, 4);
        push(2);
        wait_median("post_rst", 3);
        drain("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed hang expected finish");
        $fatal(1, "timeout");
    end

endmodule
